phy_frame_reader: RTL and testbench
===================================

Name: phy_frame_reader

Overview:
- Read-side companion of the per-channel ADC capture buffer.
- After a capture cycle is complete, walks virtual channels 0..3 in order and, per channel, emits one header word followed by that channel's stored 32-bit words on a valid/ready stream toward the host/transport packer.
- Drives the buffer's read port (vchn, address), absorbs its 1-cycle read latency, and tolerates arbitrary downstream backpressure.

Parameters:
- HDR_MARK, 8'hA5, marker placed in header bits [31:24].
- RD_LAT, 1, buffer read latency in cycles; only the value 1 is supported.

Ports:
- clk  in  1  system clock; the buffer read port is on this clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_start  in  1  one-cycle pulse issued after the capture-complete strobe; starts one frame.
- i_out_size  in  16  expected frame length in words (4 + sum of counts); sampled on accepted i_start.
- o_rd_vchn  out  2  read virtual channel select.
- i_data_count  in  8  word count for o_rd_vchn; combinational from o_rd_vchn.
- o_rd_addr  out  8  buffer read address.
- i_rd_data  in  32  buffer read data, valid RD_LAT cycles after o_rd_addr/o_rd_vchn.
- o_data  out  32  stream data.
- o_valid  out  1  stream valid.
- i_ready  in  1  stream ready; a transfer occurs when o_valid & i_ready.
- o_sop  out  1  high with the first word of a frame (ch0 header).
- o_eop  out  1  high with the last word of a frame.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse after the eop transfer.
- o_size_err  out  1  sticky; set when the transferred word total differs from the latched i_out_size; cleared by the next accepted i_start or reset.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; frame sequence counter seq = 0; output FIFO empty.
- Header word format: [31:24] HDR_MARK, [23:18] 0, [17:16] vchn, [15:8] seq, [7:0] count.
- i_start is accepted only in IDLE. On accept:
  - Latch i_out_size; clear o_size_err.
  - Set o_rd_vchn = 0; o_busy = 1; go to HDR.
- i_start while busy: ignored, no side effects.
- HDR:
  - Latch cnt = i_data_count.
  - Push the header into the output FIFO when FIFO occupancy < 2.
  - Go to DATA if cnt != 0, else NEXT.
- DATA:
  - Issue reads at o_rd_addr = 0..cnt-1.
  - Issue a read only if (FIFO occupancy + reads in flight) < 2. Returned data is pushed RD_LAT cycles later, so the FIFO never overflows.
  - After issuing address cnt-1, go to NEXT.
- NEXT:
  - If vchn == 3, go to DRAIN.
  - Else increment o_rd_vchn, reset o_rd_addr to 0, go to HDR.
- DRAIN:
  - Wait until the FIFO is empty and no read is in flight.
  - Then pulse o_done, increment seq (8-bit, wraps 255 -> 0), clear o_busy, go to IDLE.
- Output FIFO: 2 entries, first-word fall-through; o_valid = not empty.
- o_data, o_sop and o_eop are held stable while o_valid & ~i_ready (AXI-style; o_valid never drops without a transfer).
- Word counter (16-bit):
  - Cleared on accept; incremented on each transfer.
  - o_sop is high on the first word.
  - o_eop is tagged on the last pushed word: the last data word of ch3, or the ch3 header if ch3 count is 0.
- At o_done: o_size_err |= (word counter != latched i_out_size).
- Throughput: with i_ready held high and counts nonzero, one word per cycle after an initial 2-cycle fill. One bubble cycle per channel boundary is allowed.
- Count 255: addresses 0..254 are read; no address wrap within a channel.
- i_data_count is sampled only in HDR; changes at other times are ignored.
- Reset mid-frame: immediate return to IDLE, FIFO flushed, o_valid = 0, seq kept at reset value 0; no o_done.

Test Plan:
- Counts {2,0,3,1}, out_size 10, i_ready = 1:
  - 10 words in order: H0(seq0,cnt2), D0[0], D0[1], H1(cnt0), H2(cnt3), D2[0..2], H3(cnt1), D3[0].
  - sop on H0, eop on D3[0], o_done once, o_size_err = 0.
- Same frame with i_ready toggling on a pseudo-random pattern (~50%):
  - Identical word sequence, no drops or duplicates, data held stable while stalled.
- All counts 0, out_size 4:
  - Four headers only; eop on H3; no read addresses issued.
- Count 255 on ch1, others 0, out_size 259:
  - Addresses 0..254 on vchn 1; 259 words; second frame carries seq = 1.
- i_start pulsed again mid-frame:
  - Ignored; frame completes unchanged.
- Counts {1,1,1,1} with out_size given as 9:
  - o_size_err = 1 after o_done.
  - Next accepted i_start clears it.
  - rst_n asserted mid-DATA: o_valid = 0 immediately; a new i_start yields a clean frame with seq = 0.

Source files
------------

// File: rtl/phy_frame_reader.sv
// Purpose : walks virtual channels 0..3 of the capture buffer, emitting a header plus stored words per channel.
// Latency : first word (ch0 header) 2 cycles after i_start; buffer reads land RD_LAT=1 cycle after issue.
// Backpressure: o_valid/i_ready; reads are throttled so the 2-entry output FIFO never overflows.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start, i_out_size        frame start pulse and expected frame length in words
//   o_rd_vchn, o_rd_addr       buffer read port; i_data_count is the count for o_rd_vchn
//   i_rd_data                  buffer read data, one cycle after the address
//   o_data/o_valid/i_ready     output stream, with o_sop/o_eop framing
//   o_busy, o_done, o_size_err frame status

// Purpose : generic first-word-fall-through FIFO with occupancy output.
// Latency : a pushed word is visible on out_dat the cycle after the push.
// Backpressure: no input ready; the writer must respect count.
module phy_frame_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vld,
    input  logic [W-1:0]                 in_dat,
    output logic                         out_vld,
    output logic [W-1:0]                 out_dat,
    input  logic                         out_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign pop     = out_vld & out_rdy;

    always_ff @(posedge clk) begin
        if (in_vld) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (in_vld) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({in_vld, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module phy_frame_reader #(
    parameter logic [7:0] HDR_MARK = 8'hA5,
    parameter int         RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_out_size,
    output logic [1:0]  o_rd_vchn,
    input  logic [7:0]  i_data_count,
    output logic [7:0]  o_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_size_err
);
    // The in-flight accounting below tracks a single pending read.
    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("phy_frame_reader: only RD_LAT = 1 is supported");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_NEXT,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] dat;
    } word_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  seq_q;
    logic [15:0] size_q;
    logic [15:0] word_cnt_q;
    logic        rd_pend_q;
    logic        rd_pend_eop_q;

    logic        accept;
    logic        hdr_push;
    logic        rd_issue;
    logic        ch_adv;
    logic        frame_end;
    logic        rd_last;
    logic        rd_room;

    logic        fifo_in_vld;
    word_t       fifo_in;
    word_t       fifo_out;
    logic        fifo_vld;
    logic [1:0]  fifo_count;
    logic        pop;
    logic [1:0]  occ_eff;

    assign pop     = fifo_vld & i_ready;
    // Occupancy net of the word leaving this cycle: a read issued now lands
    // one cycle later, after that pop has freed its slot. This is what keeps
    // a full-rate stream possible with only two entries.
    assign occ_eff = fifo_count - {1'b0, pop};
    assign rd_room = ({1'b0, occ_eff} + {2'b00, rd_pend_q}) < 3'd2;
    assign rd_last = (o_rd_addr == cnt_q - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        hdr_push  = 1'b0;
        rd_issue  = 1'b0;
        ch_adv    = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    accept  = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                // No read can be landing here: HDR is always preceded by
                // IDLE or NEXT, neither of which issues reads.
                if (fifo_count < 2'd2) begin
                    hdr_push = 1'b1;
                    state_d  = (i_data_count != 8'd0) ? S_DATA : S_NEXT;
                end
            end
            S_DATA: begin
                if (rd_room) begin
                    rd_issue = 1'b1;
                    if (rd_last) begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (o_rd_vchn == 2'd3) begin
                    state_d = S_DRAIN;
                end else begin
                    ch_adv  = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_DRAIN: begin
                if ((fifo_count == 2'd0) && !rd_pend_q) begin
                    frame_end = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            seq_q         <= '0;
            size_q        <= '0;
            word_cnt_q    <= '0;
            rd_pend_q     <= 1'b0;
            rd_pend_eop_q <= 1'b0;
            o_rd_vchn     <= '0;
            o_rd_addr     <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_size_err    <= 1'b0;
        end else begin
            o_done        <= frame_end;
            rd_pend_q     <= rd_issue;
            rd_pend_eop_q <= rd_issue & rd_last & (o_rd_vchn == 2'd3);
            if (hdr_push) begin
                cnt_q <= i_data_count;
            end
            // Hold the last address rather than stepping past cnt-1.
            if (rd_issue && !rd_last) begin
                o_rd_addr <= o_rd_addr + 8'd1;
            end
            if (ch_adv) begin
                o_rd_vchn <= o_rd_vchn + 2'd1;
                o_rd_addr <= '0;
            end
            if (pop) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (frame_end) begin
                seq_q      <= seq_q + 8'd1;
                o_busy     <= 1'b0;
                o_size_err <= o_size_err | (word_cnt_q != size_q);
            end
            if (accept) begin
                size_q     <= i_out_size;
                o_size_err <= 1'b0;
                o_rd_vchn  <= '0;
                o_rd_addr  <= '0;
                word_cnt_q <= '0;
                o_busy     <= 1'b1;
            end
        end
    end

    always_comb begin
        fifo_in     = '0;
        fifo_in_vld = hdr_push | rd_pend_q;
        if (hdr_push) begin
            fifo_in.dat = {HDR_MARK, 6'b0, o_rd_vchn, seq_q, i_data_count};
            fifo_in.sop = (o_rd_vchn == 2'd0);
            fifo_in.eop = (o_rd_vchn == 2'd3) && (i_data_count == 8'd0);
        end else begin
            fifo_in.dat = i_rd_data;
            fifo_in.eop = rd_pend_eop_q;
        end
    end

    phy_frame_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (fifo_in_vld),
        .in_dat  (fifo_in),
        .out_vld (fifo_vld),
        .out_dat (fifo_out),
        .out_rdy (i_ready),
        .count   (fifo_count)
    );

    // Gate with valid so stale entries never show on the stream.
    assign o_valid = fifo_vld;
    assign o_data  = fifo_vld ? fifo_out.dat : 32'd0;
    assign o_sop   = fifo_vld & fifo_out.sop;
    assign o_eop   = fifo_vld & fifo_out.eop;
endmodule

// File: tb/tb_phy_frame_reader.sv
// Bench for phy_frame_reader: buffer model, expected-frame queue and a stream monitor.
module tb_phy_frame_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_out_size;
    logic [1:0]  o_rd_vchn;
    logic [7:0]  i_data_count;
    logic [7:0]  o_rd_addr;
    logic [31:0] i_rd_data;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_sop;
    logic        o_eop;
    logic        o_busy;
    logic        o_done;
    logic        o_size_err;

    always #5 clk = ~clk;

    phy_frame_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_out_size   (i_out_size),
        .o_rd_vchn    (o_rd_vchn),
        .i_data_count (i_data_count),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_sop        (o_sop),
        .o_eop        (o_eop),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_size_err   (o_size_err)
    );

    // Capture buffer model: combinational count, one-cycle read latency.
    logic [31:0] mem [4][256];
    logic [7:0]  cnts [4];
    assign i_data_count = cnts[o_rd_vchn];
    always @(posedge clk) i_rd_data <= mem[o_rd_vchn][o_rd_addr];

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          recv_cnt = 0;
    int          done_cnt = 0;
    logic [7:0]  max_addr = 8'd0;
    logic [7:0]  model_seq = 8'd0;
    bit          ready_rand = 1'b0;
    logic        stall_prev = 1'b0;
    logic [33:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor: pops the expected queue on every transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (o_done) done_cnt++;
            if (o_busy && (o_rd_addr > max_addr)) max_addr = o_rd_addr;
            if (stall_prev) begin
                chk("stall hold", 64'({o_valid, o_data, o_sop, o_eop}), 64'({1'b1, held}));
            end
            if (o_valid && i_ready) begin
                recv_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected word: got %h, expected no word", o_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("word %0d", recv_cnt), 64'({o_data, o_sop, o_eop}),
                        64'({mon_e.d, mon_e.s, mon_e.e}));
                end
            end
            stall_prev = o_valid && !i_ready;
            held = {o_data, o_sop, o_eop};
        end
    end

    // Builds the expected frame from the framing rules, then pulses i_start.
    task automatic load_frame(input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3,
                              input logic [15:0] sz);
        exp_t w;
        cnts[0] = c0;
        cnts[1] = c1;
        cnts[2] = c2;
        cnts[3] = c3;
        for (int v = 0; v < 4; v++)
            for (int a = 0; a < 256; a++) mem[v][a] = $urandom;
        for (int v = 0; v < 4; v++) begin
            w.d = {8'hA5, 6'd0, 2'(v), model_seq, cnts[v]};
            w.s = (v == 0);
            w.e = (v == 3) && (cnts[3] == 8'd0);
            exp_q.push_back(w);
            for (int i = 0; i < int'(cnts[v]); i++) begin
                w.d = mem[v][i];
                w.s = 1'b0;
                w.e = (v == 3) && (i == int'(cnts[3]) - 1);
                exp_q.push_back(w);
            end
        end
        recv_cnt = 0;
        done_cnt = 0;
        max_addr = 8'd0;
        @(posedge clk);
        #1;
        i_out_size = sz;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input logic exp_err, input int exp_len);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s timeout: no o_done within %0d cycles, required one", tag, n);
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, " done pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, " word total"}, 64'(recv_cnt), 64'(exp_len));
        chk({tag, " missing words"}, 64'(exp_q.size()), 64'd0);
        chk({tag, " size_err"}, 64'(o_size_err), 64'(exp_err));
        chk({tag, " busy"}, 64'(o_busy), 64'd0);
        model_seq = model_seq + 8'd1;
        exp_q.delete();
    endtask

    task automatic wait_words(input int n, input string tag);
        int k = 0;
        while (recv_cnt < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        chk({tag, " words before event"}, 64'(recv_cnt >= n), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        model_seq = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rc [4];
        int         sum;
        logic [15:0] sz;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_out_size = 16'd0;
        for (int v = 0; v < 4; v++) cnts[v] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset o_valid", 64'(o_valid), 64'd0);
        chk("reset o_busy", 64'(o_busy), 64'd0);
        chk("reset o_done", 64'(o_done), 64'd0);
        chk("reset o_size_err", 64'(o_size_err), 64'd0);
        chk("reset o_data", 64'(o_data), 64'd0);
        chk("reset o_sop/o_eop", 64'({o_sop, o_eop}), 64'd0);
        chk("reset o_rd_vchn/o_rd_addr", 64'({o_rd_vchn, o_rd_addr}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        load_frame(8'd2, 8'd0, 8'd3, 8'd1, 16'd10);
        finish_frame("basic", 1'b0, 10);

        ready_rand = 1'b1;
        load_frame(8'd2, 8'd0, 8'd3, 8'd1, 16'd10);
        finish_frame("stalled", 1'b0, 10);
        ready_rand = 1'b0;

        load_frame(8'd0, 8'd0, 8'd0, 8'd0, 16'd4);
        finish_frame("headers only", 1'b0, 4);
        chk("headers only max addr", 64'(max_addr), 64'd0);

        do_reset();
        load_frame(8'd0, 8'd255, 8'd0, 8'd0, 16'd259);
        finish_frame("count255", 1'b0, 259);
        chk("count255 max addr", 64'(max_addr), 64'd254);
        load_frame(8'd0, 8'd1, 8'd0, 8'd0, 16'd5);
        finish_frame("seq1 frame", 1'b0, 5);

        ready_rand = 1'b1;
        load_frame(8'd3, 8'd2, 8'd4, 8'd1, 16'd14);
        wait_words(3, "restart");
        @(posedge clk);
        #1;
        i_out_size = 16'd1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        finish_frame("restart ignored", 1'b0, 14);
        ready_rand = 1'b0;

        load_frame(8'd1, 8'd1, 8'd1, 8'd1, 16'd9);
        finish_frame("size mismatch", 1'b1, 8);
        load_frame(8'd1, 8'd1, 8'd1, 8'd1, 16'd8);
        chk("size_err cleared on start", 64'(o_size_err), 64'd0);
        wait_words(3, "mid reset");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid reset o_valid", 64'(o_valid), 64'd0);
        chk("mid reset o_busy", 64'(o_busy), 64'd0);
        exp_q.delete();
        model_seq = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset done count", 64'(done_cnt), 64'd0);
        load_frame(8'd1, 8'd1, 8'd1, 8'd1, 16'd8);
        finish_frame("clean after reset", 1'b0, 8);

        ready_rand = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sum = 0;
            for (int v = 0; v < 4; v++) begin
                rc[v] = 8'($urandom_range(0, 5));
                sum += int'(rc[v]);
            end
            sz = 16'(4 + sum + (($urandom_range(0, 2) == 0) ? 1 : 0));
            load_frame(rc[0], rc[1], rc[2], rc[3], sz);
            finish_frame($sformatf("random %0d", k), sz != 16'(4 + sum), 4 + sum);
        end
        ready_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
